conv_stream: RTL and testbench
==============================

# conv_stream

Streaming, parametrised single-layer KxK convolution engine for the NPU datapath, the next generation of the fixed two-layer array-port `conv` block. It takes a feature map one pixel per handshake in raster order, keeps a rolling K-row line buffer, and emits OUT_CH valid-region (no padding, stride 1) results per window position over a valid/ready stream. Weights are loaded through a write port, and the block adds ReLU/bypass mode, output saturation and backpressure.

## Interface
- DATA_W, 8: input pixel width.
- IN_SIGNED, 0: 0 = pixels unsigned (zero-extended), 1 = signed.
- W_W, 8: signed weight width.
- ACC_W, 24: signed output width; results saturate to this width.
- K, 3: kernel height and width.
- IN_H, 16 / IN_W, 15: input map rows / columns.
- OUT_CH, 10: number of output channels (kernels).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- w_wr_en  in  1  weight write strobe.
- w_wr_addr  in  clog2(OUT_CH*K*K)  weight index = ch*K*K + r*K + c.
- w_wr_data  in  W_W  signed weight value.
- start  in  1  begin a frame; sampled only in IDLE.
- cfg_relu  in  1  sampled with start: 1 = clamp negative results to 0.
- busy  out  1  high from the cycle after start until frame end.
- done  out  1  one-cycle pulse at frame end.
- in_valid  in  1  pixel valid.
- in_ready  out  1  pixel accepted when in_valid && in_ready.
- in_data  in  DATA_W  pixel.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  ACC_W  signed result.
- out_ch / out_row / out_col  out  clog2 widths  channel and output coordinates of out_data.
- out_last  out  1  high with the final result of the frame.

## Operation
- States: IDLE, STREAM, EMIT.
- IDLE: in_ready=0 and out_valid=0. A weight write updates the entry on the rising edge. start latches cfg_relu, clears the row/col counters, and moves to STREAM.
- STREAM: in_ready=1. Each accepted pixel is written to the line buffer at (row, col), then col advances; at IN_W-1, col wraps to 0 and row increments.
- If the accepted pixel has row>=K-1 and col>=K-1, the window with top-left (row-K+1, col-K+1) is complete. The FSM then moves to EMIT with channel index 0.
- EMIT: in_ready=0. out_data is the channel-ch result over the current window. Each out handshake increments ch.
  - After the OUT_CH-1 handshake: return to STREAM, or go to IDLE if this was the last window.
  - Output order: row-major positions; channels 0..OUT_CH-1 within each position.
- Arithmetic:
  - Each product is pixel (extended per IN_SIGNED) times a signed weight.
  - K*K products are summed at full precision: DATA_W+W_W+clog2(K*K)+1 bits.
  - The sum is saturated to signed ACC_W [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - If relu_latched is set, negative values become 0 after saturation.
- Output count per frame is (IN_H-K+1)*(IN_W-K+1)*OUT_CH.
- Ignored events:
  - w_wr_en while busy: no weight change.
  - start while busy.
  - in_valid outside STREAM.
- Line buffer holds K rows × IN_W pixels and indexes rows modulo K. No full-frame storage.

## Timing
- Reset (async assert, sync deassert use): state IDLE, all counters 0, weights 0, relu_latched 0. Outputs: busy, done, in_ready, out_valid, out_last, out_data, out_ch, out_row, out_col all 0.
- start in IDLE at edge t: busy=1 and in_ready=1 from t+1.
- The window-completing pixel accepted at edge t gives out_valid=1 from t+1. in_ready falls at t+1.
- out_data and coordinates hold stable while out_valid && !out_ready.
- The next channel appears the cycle after each handshake, so there is one result per cycle under continuous out_ready.
- Last channel handshake at t (non-final window): in_ready=1 at t+1.
- Final handshake at t: done=1 for cycle t+1, busy=0 and state IDLE at t+1. out_last is asserted only on that final result.
- Reset asserted mid-frame aborts immediately. Partial results are discarded and weights are cleared. A new frame needs reloaded weights and start.

## Test plan
All scenarios use K=3, IN_H=IN_W=4, OUT_CH=2, ACC_W=24 unless stated.
- Ch0 weights all +1, ch1 all -1, image all 1, relu=0 -> 8 outputs alternating 9, -9 at (0,0),(0,1),(1,0),(1,1). out_last on the 8th output. done one cycle later.
- Same setup with relu=1 -> ch0 outputs 9, ch1 outputs 0.
- ACC_W=12, image all 255:
  - weights all 127 -> 2047 (sum 291465 saturates).
  - weights all -128 -> -2048.
- Image pixel = row*4+col, ch0 weight 1 at (1,1) only -> outputs 5, 6, 9, 10 (window centres).
- Hold out_ready=0 for 5 cycles at the first result -> out_data stable, in_ready=0, no pixels accepted. Stream resumes one result per cycle after release.
- Reset after 7 pixels -> all outputs 0 and busy 0. start while busy and w_wr_en while busy have no effect. A reloaded full frame reproduces scenario 1.

Source files
------------

// File: rtl/conv_stream.sv
// Streaming KxK valid-region convolution engine.
// Pixels arrive in raster order and are stored in a K-row rolling line buffer.
// When a window is complete, OUT_CH results are produced for it, one channel
// per output handshake, before input resumes.
module conv_stream #(
    parameter int DATA_W    = 8,
    parameter int IN_SIGNED = 0,
    parameter int W_W       = 8,
    parameter int ACC_W     = 24,
    parameter int K         = 3,
    parameter int IN_H      = 16,
    parameter int IN_W      = 15,
    parameter int OUT_CH    = 10,
    localparam int NW       = OUT_CH * K * K,
    localparam int AW       = (NW > 1) ? $clog2(NW) : 1,
    localparam int CHW      = (OUT_CH > 1) ? $clog2(OUT_CH) : 1,
    localparam int RW       = (IN_H > 1) ? $clog2(IN_H) : 1,
    localparam int CW       = (IN_W > 1) ? $clog2(IN_W) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_wr_en,
    input  logic [AW-1:0]     w_wr_addr,
    input  logic [W_W-1:0]    w_wr_data,
    input  logic              start,
    input  logic              cfg_relu,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [CHW-1:0]    out_ch,
    output logic [RW-1:0]     out_row,
    output logic [CW-1:0]     out_col,
    output logic              out_last
);

    localparam int SW    = (K > 1) ? $clog2(K) : 1;
    // Full-precision sum width, widened to ACC_W so saturation compares work
    // regardless of which of the two is larger.
    localparam int SUM_W = DATA_W + W_W + $clog2(K * K) + 1;
    localparam int EXT_W = (SUM_W > ACC_W) ? SUM_W : ACC_W;

    localparam logic [RW-1:0]  ROW_KM1   = RW'(K - 1);
    localparam logic [RW-1:0]  ROW_LAST  = RW'(IN_H - 1);
    localparam logic [RW-1:0]  OROW_LAST = RW'(IN_H - K);
    localparam logic [CW-1:0]  COL_KM1   = CW'(K - 1);
    localparam logic [CW-1:0]  COL_LAST  = CW'(IN_W - 1);
    localparam logic [CW-1:0]  OCOL_LAST = CW'(IN_W - K);
    localparam logic [CHW-1:0] CH_LAST   = CHW'(OUT_CH - 1);
    localparam logic [SW-1:0]  SLOT_LAST = SW'(K - 1);

    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_EMIT
    } state_t;

    state_t              r_state;
    logic                r_relu;
    logic [RW-1:0]       r_row;
    logic [CW-1:0]       r_col;
    logic [SW-1:0]       r_slot;
    logic [SW-1:0]       r_bot_slot;
    logic [CHW-1:0]      r_ch;
    logic [RW-1:0]       r_out_row;
    logic [CW-1:0]       r_out_col;
    logic                r_busy;
    logic                r_done;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_out_last;

    logic signed [W_W-1:0] r_wt [NW];
    logic [DATA_W-1:0]     r_lb [K][IN_W];

    logic                    w_win_done;
    logic                    w_pix_final;
    logic                    w_final_win;
    logic signed [EXT_W-1:0] w_sum;
    logic [ACC_W-1:0]        w_res;

    // Buffer slot of window row i, given the slot holding the window's bottom row.
    function automatic logic [SW-1:0] slot_of(input logic [SW-1:0] bot, input int i);
        int s;
        s = int'(bot) + 1 + i;
        if (s >= K) s = s - K;
        return SW'(s);
    endfunction

    function automatic logic signed [EXT_W-1:0] ext_px(input logic [DATA_W-1:0] p);
        logic fill;
        fill = (IN_SIGNED != 0) ? p[DATA_W-1] : 1'b0;
        return {{(EXT_W-DATA_W){fill}}, p};
    endfunction

    function automatic logic signed [EXT_W-1:0] ext_wt(input logic [W_W-1:0] w);
        return {{(EXT_W-W_W){w[W_W-1]}}, w};
    endfunction

    assign w_win_done  = (r_row >= ROW_KM1) && (r_col >= COL_KM1);
    assign w_pix_final = (r_row == ROW_LAST) && (r_col == COL_LAST);
    assign w_final_win = (r_out_row == OROW_LAST) && (r_out_col == OCOL_LAST);

    // Weight store: writable only while idle, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) r_wt[i] <= '0;
        end else if (r_state == S_IDLE && w_wr_en && int'(w_wr_addr) < NW) begin
            r_wt[w_wr_addr] <= w_wr_data;
        end
    end

    // Line buffer write of each accepted pixel into its row slot.
    always_ff @(posedge clk) begin
        if (r_state == S_STREAM && in_valid) begin
            r_lb[r_slot][r_col] <= in_data;
        end
    end

    // Multiply-accumulate of the current window against channel r_ch.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                w_sum = w_sum + ext_px(r_lb[slot_of(r_bot_slot, i)][CW'(int'(r_out_col) + j)])
                              * ext_wt(r_wt[AW'(int'(r_ch) * K * K + i * K + j)]);
            end
        end
    end

    // Saturate to ACC_W, then optional ReLU.
    always_comb begin
        if (w_sum > SAT_MAX) begin
            w_res = {1'b0, {(ACC_W-1){1'b1}}};
        end else if (w_sum < SAT_MIN) begin
            w_res = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            w_res = w_sum[ACC_W-1:0];
        end
        if (r_relu && w_res[ACC_W-1]) w_res = '0;
    end

    // Frame sequencing: IDLE -> STREAM <-> EMIT -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_relu      <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
            r_slot      <= '0;
            r_bot_slot  <= '0;
            r_ch        <= '0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_relu     <= cfg_relu;
                        r_row      <= '0;
                        r_col      <= '0;
                        r_slot     <= '0;
                        r_ch       <= '0;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b1;
                        r_state    <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (in_valid) begin
                        if (r_col == COL_LAST) begin
                            r_col  <= '0;
                            r_row  <= r_row + RW'(1);
                            r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + SW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                        if (w_win_done) begin
                            r_out_row   <= r_row - ROW_KM1;
                            r_out_col   <= r_col - COL_KM1;
                            r_bot_slot  <= r_slot;
                            r_ch        <= '0;
                            r_out_valid <= 1'b1;
                            r_out_last  <= w_pix_final && (OUT_CH == 1);
                            r_in_ready  <= 1'b0;
                            r_state     <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (r_ch == CH_LAST) begin
                            r_ch        <= '0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            if (w_final_win) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_in_ready <= 1'b1;
                                r_state    <= S_STREAM;
                            end
                        end else begin
                            r_ch       <= r_ch + CHW'(1);
                            r_out_last <= w_final_win && (r_ch + CHW'(1) == CH_LAST);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_valid ? w_res : '0;
    assign out_ch    = r_ch;
    assign out_row   = r_out_row;
    assign out_col   = r_out_col;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_conv_stream.sv
// Bench for conv_stream: two instances (ACC_W=24 and ACC_W=12) share all
// inputs; every result is compared with a direct window-sum model.
module tb_conv_stream;

    localparam int K    = 3;
    localparam int H    = 4;
    localparam int W    = 4;
    localparam int NCH  = 2;
    localparam int OW   = W - K + 1;
    localparam int NOUT = (H - K + 1) * OW * NCH;
    localparam int NWT  = NCH * K * K;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       w_wr_en = 1'b0;
    logic [4:0] w_wr_addr = '0;
    logic [7:0] w_wr_data = '0;
    logic       start = 1'b0;
    logic       cfg_relu = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_ready = 1'b0;

    logic              a_busy, a_done, a_in_ready, a_out_valid, a_out_last;
    logic signed [23:0] a_data;
    logic [0:0]        a_ch;
    logic [1:0]        a_row, a_col;
    logic              b_busy, b_done, b_in_ready, b_out_valid, b_out_last;
    logic signed [11:0] b_data;
    logic [0:0]        b_ch;
    logic [1:0]        b_row, b_col;

    conv_stream #(.DATA_W(8), .IN_SIGNED(0), .W_W(8), .ACC_W(24), .K(K),
                  .IN_H(H), .IN_W(W), .OUT_CH(NCH)) u24 (
        .clk(clk), .rst_n(rst_n), .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr),
        .w_wr_data(w_wr_data), .start(start), .cfg_relu(cfg_relu),
        .busy(a_busy), .done(a_done), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_data), .out_ch(a_ch), .out_row(a_row), .out_col(a_col),
        .out_last(a_out_last));

    conv_stream #(.DATA_W(8), .IN_SIGNED(0), .W_W(8), .ACC_W(12), .K(K),
                  .IN_H(H), .IN_W(W), .OUT_CH(NCH)) u12 (
        .clk(clk), .rst_n(rst_n), .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr),
        .w_wr_data(w_wr_data), .start(start), .cfg_relu(cfg_relu),
        .busy(b_busy), .done(b_done), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_data), .out_ch(b_ch), .out_row(b_row), .out_col(b_col),
        .out_last(b_out_last));

    int total = 0;
    int bad   = 0;
    int img [H*W];
    int wt  [NWT];

    typedef struct {
        int wmode;   // 0: ch0 +1 / ch1 -1, 1: all 127, 2: all -128, 3: ch0 centre 1
        int imode;   // 0: all 1, 1: all 255, 2: row*4+col
        int relu;
        int stall;   // cycles of out_ready=0 at the first result
        int e0_24;   // first result ch0, ACC_W=24
        int e1_24;   // first result ch1, ACC_W=24
        int e0_12;   // first result ch0, ACC_W=12
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int model(int r, int c, int ch, int accw, int relu);
        int s, mx, mn;
        s = 0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                s += img[(r + i) * W + c + j] * wt[ch * K * K + i * K + j];
        mx = (1 << (accw - 1)) - 1;
        mn = -(1 << (accw - 1));
        if (s > mx) s = mx;
        if (s < mn) s = mn;
        if (relu != 0 && s < 0) s = 0;
        return s;
    endfunction

    task automatic set_pattern(input int wmode, input int imode);
        for (int a = 0; a < NWT; a++) begin
            case (wmode)
                0: wt[a] = (a < K * K) ? 1 : -1;
                1: wt[a] = 127;
                2: wt[a] = -128;
                default: wt[a] = (a == 4) ? 1 : 0;
            endcase
        end
        for (int p = 0; p < H * W; p++) begin
            case (imode)
                0: img[p] = 1;
                1: img[p] = 255;
                default: img[p] = p;
            endcase
        end
    endtask

    task automatic load_weights();
        for (int a = 0; a < NWT; a++) begin
            @(negedge clk);
            w_wr_en   = 1'b1;
            w_wr_addr = 5'(a);
            w_wr_data = 8'(wt[a]);
        end
        @(negedge clk);
        w_wr_en = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, int'(a_busy), 0);
        chk({tag, "_done"}, int'(a_done), 0);
        chk({tag, "_in_ready"}, int'(a_in_ready), 0);
        chk({tag, "_out_valid"}, int'(a_out_valid), 0);
        chk({tag, "_out_last"}, int'(a_out_last), 0);
        chk({tag, "_data"}, int'(a_data), 0);
        chk({tag, "_coords"}, int'({a_ch, a_row, a_col}), 0);
    endtask

    // One full frame; all results checked against the model.
    task automatic run_frame(input int relu, input int stall, input bit rnd, input bit poke,
                             output int f0a, output int f1a, output int f0b);
        int pix, nout, cyc, stall_left, r, c, ch, win;
        bit prev_win, prev_mid, prev_chlast, hs;
        f0a = 0; f1a = 0; f0b = 0;
        @(negedge clk);
        start = 1'b1;
        cfg_relu = relu[0];
        @(negedge clk);
        start = 1'b0;
        cfg_relu = 1'b0;
        chk("start_busy", int'(a_busy), 1);
        chk("start_in_ready", int'(a_in_ready), 1);
        pix = 0; nout = 0; cyc = 0; stall_left = stall;
        prev_win = 1'b0; prev_mid = 1'b0; prev_chlast = 1'b0;
        while (nout < NOUT && cyc < 2000) begin
            if (prev_win) begin
                chk("win_latency_valid", int'(a_out_valid), 1);
                chk("win_latency_in_ready", int'(a_in_ready), 0);
            end
            if (prev_mid) chk("one_per_cycle", int'(a_out_valid), 1);
            if (prev_chlast) chk("resume_in_ready", int'(a_in_ready), 1);
            prev_win = 1'b0; prev_mid = 1'b0; prev_chlast = 1'b0;

            w_wr_en = 1'b0;
            start = 1'b0;
            cfg_relu = 1'b0;
            if (poke && cyc == 2) begin
                start = 1'b1;
                cfg_relu = ~relu[0];
                w_wr_en = 1'b1;
                w_wr_addr = 5'd0;
                w_wr_data = 8'd50;
            end

            if (pix < H * W) begin
                in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data  = 8'(img[pix]);
            end else begin
                in_valid = 1'b0;
            end

            hs = 1'b0;
            if (a_out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                chk("stall_in_ready", int'(a_in_ready), 0);
                chk("stall_hold", int'(a_data), model(0, 0, 0, 24, relu));
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                hs = a_out_valid && out_ready;
            end

            if (hs) begin
                win = nout / NCH;
                ch  = nout % NCH;
                r   = win / OW;
                c   = win % OW;
                chk("data24", int'(a_data), model(r, c, ch, 24, relu));
                chk("data12", int'(b_data), model(r, c, ch, 12, relu));
                chk("out_ch", int'(a_ch), ch);
                chk("out_row", int'(a_row), r);
                chk("out_col", int'(a_col), c);
                chk("out_last", int'(a_out_last), (nout == NOUT - 1) ? 1 : 0);
                if (nout == 0) begin f0a = int'(a_data); f0b = int'(b_data); end
                if (nout == 1) f1a = int'(a_data);
                if (ch != NCH - 1) prev_mid = 1'b1;
                else if (nout != NOUT - 1) prev_chlast = 1'b1;
                nout++;
            end

            if (in_valid && a_in_ready) begin
                prev_win = ((pix / W) >= K - 1) && ((pix % W) >= K - 1);
                pix++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        w_wr_en = 1'b0;
        start = 1'b0;
        if (nout < NOUT) begin
            total++;
            bad++;
            $display("FAIL frame_timeout outputs=%0d expected=%0d", nout, NOUT);
        end else begin
            chk("done_pulse", int'(a_done), 1);
            chk("end_busy", int'(a_busy), 0);
            chk("end_out_valid", int'(a_out_valid), 0);
            chk("end_in_ready", int'(a_in_ready), 0);
            @(negedge clk);
            chk("done_one_cycle", int'(a_done), 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv [5];
        int f0a, f1a, f0b, n, cyc;
        int relu;

        tv[0] = '{0, 0, 0, 5,       9,      -9,     9};
        tv[1] = '{0, 0, 1, 0,       9,       0,     9};
        tv[2] = '{1, 1, 0, 0,  291465,  291465,  2047};
        tv[3] = '{2, 1, 0, 0, -293760, -293760, -2048};
        tv[4] = '{3, 2, 0, 0,       5,       0,     5};

        #13;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            set_pattern(tv[v].wmode, tv[v].imode);
            load_weights();
            run_frame(tv[v].relu, tv[v].stall, 1'b0, 1'b0, f0a, f1a, f0b);
            chk("tbl_first_ch0_24", f0a, tv[v].e0_24);
            chk("tbl_first_ch1_24", f1a, tv[v].e1_24);
            chk("tbl_first_ch0_12", f0b, tv[v].e0_12);
        end

        for (int f = 0; f < 6; f++) begin
            for (int a = 0; a < NWT; a++) wt[a] = int'($urandom_range(0, 255)) - 128;
            for (int p = 0; p < H * W; p++) img[p] = int'($urandom_range(0, 255));
            relu = int'($urandom_range(0, 1));
            load_weights();
            run_frame(relu, 0, 1'b1, 1'b0, f0a, f1a, f0b);
        end

        // Abort a frame after 7 accepted pixels.
        set_pattern(0, 0);
        load_weights();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        cyc = 0;
        while (n < 7 && cyc < 100) begin
            in_valid = 1'b1;
            in_data = 8'(img[n]);
            if (a_in_ready) n++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("pre_reset_busy", int'(a_busy), 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        // Weights were cleared by reset: a frame without reload yields zeros.
        for (int a = 0; a < NWT; a++) wt[a] = 0;
        run_frame(0, 0, 1'b0, 1'b0, f0a, f1a, f0b);
        chk("cleared_wt_ch0", f0a, 0);

        // Reload and rerun scenario 1 while poking start/w_wr_en mid-frame.
        set_pattern(0, 0);
        load_weights();
        run_frame(0, 0, 1'b0, 1'b1, f0a, f1a, f0b);
        chk("reload_ch0", f0a, 9);
        chk("reload_ch1", f1a, -9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
